cpr_loader: RTL

- Streaming parser for Amstrad Plus/GX4000 cartridge (.CPR, RIFF "AMS!") files. Sits between the ioctl download port and the boot-write path that feeds SDRAM.
- Strips the RIFF framing and turns each "cbNN" chunk into bank-addressed byte writes, held in a one-entry output buffer with a request/acknowledge handshake.
- Raises plus_valid only when a well-formed cartridge has been fully written.

---
 rtl/cpr_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cpr_loader.sv
// Streaming parser for Amstrad Plus/GX4000 .CPR (RIFF "AMS!") cartridge images.
// Turns "cbNN" chunk payloads into bank-addressed byte writes through a one-entry buffer.
`timescale 1ns/1ps
module cpr_loader #(
  parameter logic [7:0] CPR_INDEX = 8'd5,
  parameter logic [7:0] BASE_PAGE = 8'h00,
  parameter int         MAX_BANKS = 32
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        out_req,
  output logic [22:0] out_addr,
  output logic [7:0]  out_data,
  input  logic        out_ack,
  output logic        plus_valid,
  output logic        load_error,
  output logic [31:0] banks_loaded,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_HDR  = 4'd1,
    S_CID  = 4'd2,
    S_CLEN = 4'd3,
    S_DATA = 4'd4,
    S_SKIP = 4'd5,
    S_PAD  = 4'd6,
    S_DONE = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  state_t      state;
  state_t      st_eff;
  logic        session, session_q, start, stop, stop_ok;
  logic [24:0] byte_cnt, cnt_eff;
  logic [3:0]  sub_cnt, sub_eff;
  logic [31:0] chunk_id;
  logic [23:0] len_lo, rem, data_off;
  logic        len_odd;
  logic [4:0]  bank;
  logic        take, byte_err, is_cb, bank_ok, hdr_bad;
  logic [6:0]  bank_num;

  // Handshake: out_req holds one write with out_addr/out_data stable until
  // out_ack is sampled high; it drops on the following edge. ioctl_wait mirrors out_req.
  assign ioctl_wait = out_req;
  assign dbg_state  = state;

  assign session = ioctl_download && (ioctl_index == CPR_INDEX);
  assign start   = session && !session_q;
  assign stop    = !session && session_q;
  assign stop_ok = (state == S_CID) && (sub_cnt == 4'd0) && (banks_loaded != 32'd0) && !load_error;

  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    case (i)
      4'd0:       hdr_byte = 8'h52;
      4'd1:       hdr_byte = 8'h49;
      4'd2, 4'd3: hdr_byte = 8'h46;
      4'd8:       hdr_byte = 8'h41;
      4'd9:       hdr_byte = 8'h4D;
      4'd10:      hdr_byte = 8'h53;
      4'd11:      hdr_byte = 8'h21;
      default:    hdr_byte = 8'h00;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    is_digit = (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // A byte arriving on the same cycle the session opens is parsed as header byte 0.
  always_comb begin
    st_eff  = start ? S_HDR : state;
    cnt_eff = start ? 25'd0 : byte_cnt;
    sub_eff = start ? 4'd0 : sub_cnt;
    take    = session && ioctl_wr &&
              (st_eff == S_HDR || st_eff == S_CID || st_eff == S_CLEN ||
               st_eff == S_DATA || st_eff == S_SKIP || st_eff == S_PAD);
    is_cb   = (chunk_id[7:0] == 8'h63) && (chunk_id[15:8] == 8'h62) &&
              is_digit(chunk_id[23:16]) && is_digit(chunk_id[31:24]);
    bank_num = ({3'b000, chunk_id[19:16]} * 7'd10) + {3'b000, chunk_id[27:24]};
    bank_ok  = int'(bank_num) < MAX_BANKS;
    hdr_bad  = ((sub_eff < 4'd4) || (sub_eff >= 4'd8)) && (ioctl_dout != hdr_byte(sub_eff));
    byte_err = 1'b0;
    if (take) begin
      if (out_req || (ioctl_addr != cnt_eff)) begin
        byte_err = 1'b1;
      end else begin
        case (st_eff)
          S_HDR:  byte_err = hdr_bad;
          S_CLEN: if (sub_eff == 4'd3)
                    byte_err = (ioctl_dout != 8'h00) || ((len_lo != 24'd0) && is_cb && !bank_ok);
          default: byte_err = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      session_q    <= 1'b0;
      byte_cnt     <= 25'd0;
      sub_cnt      <= 4'd0;
      chunk_id     <= 32'd0;
      len_lo       <= 24'd0;
      rem          <= 24'd0;
      len_odd      <= 1'b0;
      data_off     <= 24'd0;
      bank         <= 5'd0;
      out_req      <= 1'b0;
      out_addr     <= 23'd0;
      out_data     <= 8'd0;
      plus_valid   <= 1'b0;
      load_error   <= 1'b0;
      banks_loaded <= 32'd0;
    end else begin
      session_q <= session;
      if (out_req && out_ack) out_req <= 1'b0;
      if (state == S_DONE && (!out_req || out_ack)) plus_valid <= 1'b1;

      if (start) begin
        state        <= S_HDR;
        plus_valid   <= 1'b0;
        load_error   <= 1'b0;
        banks_loaded <= 32'd0;
        byte_cnt     <= 25'd0;
        sub_cnt      <= 4'd0;
      end

      if (take) begin
        if (byte_err) begin
          state      <= S_ERR;
          load_error <= 1'b1;
          plus_valid <= 1'b0;
        end else begin
          byte_cnt <= cnt_eff + 25'd1;
          case (st_eff)
            S_HDR: begin
              if (sub_eff == 4'd11) begin
                state   <= S_CID;
                sub_cnt <= 4'd0;
              end else begin
                sub_cnt <= sub_eff + 4'd1;
              end
            end
            S_CID: begin
              chunk_id[8*sub_eff[1:0] +: 8] <= ioctl_dout;
              if (sub_eff == 4'd3) begin
                state   <= S_CLEN;
                sub_cnt <= 4'd0;
              end else begin
                sub_cnt <= sub_eff + 4'd1;
              end
            end
            S_CLEN: begin
              case (sub_eff[1:0])
                2'd0: len_lo[7:0]   <= ioctl_dout;
                2'd1: len_lo[15:8]  <= ioctl_dout;
                2'd2: len_lo[23:16] <= ioctl_dout;
                default: begin
                  rem      <= len_lo;
                  len_odd  <= len_lo[0];
                  data_off <= 24'd0;
                  bank     <= bank_num[4:0];
                  if (len_lo == 24'd0) state <= S_CID;
                  else if (is_cb)      state <= S_DATA;
                  else                 state <= S_SKIP;
                end
              endcase
              sub_cnt <= (sub_eff == 4'd3) ? 4'd0 : sub_eff + 4'd1;
            end
            S_DATA, S_SKIP: begin
              if (st_eff == S_DATA && data_off < 24'd16384) begin
                out_req            <= 1'b1;
                out_addr           <= {1'b1, BASE_PAGE + {3'b000, bank}, data_off[13:0]};
                out_data           <= ioctl_dout;
                banks_loaded[bank] <= 1'b1;
              end
              data_off <= data_off + 24'd1;
              rem      <= rem - 24'd1;
              if (rem == 24'd1) state <= len_odd ? S_PAD : S_CID;
            end
            S_PAD:   state <= S_CID;
            default: state <= state;
          endcase
        end
      end

      if (stop) begin
        if (stop_ok) begin
          state <= S_DONE;
        end else begin
          state      <= S_ERR;
          load_error <= 1'b1;
          plus_valid <= 1'b0;
        end
      end
    end
  end

endmodule
